// File: rtl/intra_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intra_pkg
// Description : Shared definitions for the luma 4x4 intra path: default
//               pixel value, block dimension, writer FSM states and the
//               block-index / pixel helpers (also used by the extractor).
// Revision    : 1.0 - initial release
// ============================================================================
package intra_pkg;

    localparam logic [7:0] PIX_DEFAULT = 8'd128;
    localparam int         BLK_DIM     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Block row of a raster 4x4-block index, given blocks per frame row.
    function automatic int blk_row(input logic [12:0] idx, input int cols);
        return int'(idx) / cols;
    endfunction

    // Block column of a raster 4x4-block index, given blocks per frame row.
    function automatic int blk_col(input logic [12:0] idx, input int cols);
        return int'(idx) % cols;
    endfunction

    // Row r of a 16-pixel block as one RAM word; byte k is pixel (r, k).
    function automatic logic [31:0] row_word(input logic [127:0] blk, input logic [1:0] r);
        return blk[32*r +: 32];
    endfunction

endpackage
`default_nettype wire

// File: rtl/recon_frame_ram.sv
`default_nettype none
// ============================================================================
// Module      : recon_frame_ram
// Description : Single-port synchronous frame RAM, 32-bit words, one-cycle
//               read latency, no reset. Returns both the full word and one
//               selected byte of it.
// Ports       : i_en/i_we/i_addr/i_wdata - access request
//               i_bsel  - byte lane for o_rbyte
//               o_rdata - word read, valid the cycle after the request
//               o_rbyte - selected byte of that word
// Revision    : 1.0 - initial release
// ============================================================================
module recon_frame_ram #(
    parameter int DEPTH = 16384,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    input  logic [1:0]    i_bsel,
    output logic [31:0]   o_rdata,
    output logic [7:0]    o_rbyte
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en && (int'(i_addr) < DEPTH)) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                o_rdata <= r_mem[i_addr];
                o_rbyte <= r_mem[i_addr][8*i_bsel +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/recon_writer_luma4x4.sv
`default_nettype none
// ============================================================================
// Module      : recon_writer_luma4x4
// Description : Stores reconstructed 4x4 luma blocks into the frame RAM and
//               serves the top (8) and left (corner + 4) neighbour pixels of
//               any block from that RAM, substituting 128 at frame edges.
// Ports       : in_valid/in_ready/blknumber/blk - block write handshake
//               nb_req/nb_blknumber             - neighbour request (level)
//               nb_valid/toppixels/leftpixels   - neighbour response
//               busy - FSM not idle; err - out-of-range index pulse
// Revision    : 1.0 - initial release
// ============================================================================
module recon_writer_luma4x4
    import intra_pkg::*;
#(
    parameter int LENGTH = 256,
    parameter int WIDTH  = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [12:0]  blknumber,
    input  logic [127:0] blk,
    input  logic         nb_req,
    input  logic [12:0]  nb_blknumber,
    output logic         nb_valid,
    output logic [63:0]  toppixels,
    output logic [39:0]  leftpixels,
    output logic         busy,
    output logic         err
);

    localparam int          BLK_COLS     = WIDTH / BLK_DIM;
    localparam int          NUM_BLKS     = BLK_COLS * (LENGTH / BLK_DIM);
    localparam int          WORDS        = LENGTH * WIDTH / 4;
    localparam int          AW           = $clog2(WORDS);
    localparam logic [63:0] TOP_DEFAULT  = {8{PIX_DEFAULT}};
    localparam logic [39:0] LEFT_DEFAULT = {5{PIX_DEFAULT}};

    state_t       r_state;
    state_t       w_state_nxt;
    logic [2:0]   r_cnt;
    logic [12:0]  r_idx;
    logic         r_oob;
    logic [127:0] r_blk;
    logic         r_in_ready;
    logic         r_err;
    logic [31:0]  r_top_lo;
    logic [31:0]  r_top_hi;
    logic [31:0]  r_left_lo;     // left pixels 0..3; pixel 4 comes straight from the RAM
    logic [63:0]  r_top_out;
    logic [39:0]  r_left_out;

    logic         w_accept_wr;
    logic         w_accept_rd;
    logic         w_new_oob;
    logic [12:0]  w_new_idx;
    int           w_brow;
    int           w_bcol;
    int           w_row_above;
    logic         w_y0;
    logic         w_x0;
    logic         w_xr;
    logic         w_ram_en;
    logic         w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [31:0]  w_ram_wdata;
    logic [1:0]   w_ram_bsel;
    logic [31:0]  w_ram_rdata;
    logic [7:0]   w_ram_rbyte;
    logic [63:0]  w_top_asm;
    logic [39:0]  w_left_asm;

    // in_ready is registered so it stays low through reset and rises one
    // clock after release; it therefore also qualifies IDLE acceptance.
    assign w_accept_wr = (r_state == ST_IDLE) && r_in_ready && in_valid;
    assign w_accept_rd = (r_state == ST_IDLE) && r_in_ready && !in_valid && nb_req;
    assign w_new_idx   = in_valid ? blknumber : nb_blknumber;
    assign w_new_oob   = (int'(w_new_idx) >= NUM_BLKS);

    assign in_ready   = r_in_ready;
    assign err        = r_err;
    assign busy       = (r_state != ST_IDLE);
    assign nb_valid   = (r_state == ST_RESP);
    assign toppixels  = r_top_out;
    assign leftpixels = r_left_out;

    always_comb begin
        w_brow      = blk_row(r_idx, BLK_COLS);
        w_bcol      = blk_col(r_idx, BLK_COLS);
        w_row_above = BLK_DIM * w_brow - 1;
        w_y0        = (w_brow == 0);
        w_x0        = (w_bcol == 0);
        w_xr        = (w_bcol == BLK_COLS - 1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept_wr)      w_state_nxt = ST_WR;
                else if (w_accept_rd) w_state_nxt = ST_RD;
            end
            ST_WR:   if (r_oob || (r_cnt == 3'd3)) w_state_nxt = ST_IDLE;
            ST_RD:   if (r_cnt == 3'd7) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // RAM access: WR writes rows 0..3; RD issues 7 reads in counts 0..6 and
    // uses count 7 only to collect the last returned byte. Addresses for
    // edge-substituted pixels may wrap; their data is discarded.
    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_ram_bsel  = 2'd0;
        w_ram_wdata = row_word(r_blk, r_cnt[1:0]);
        case (r_state)
            ST_WR: begin
                if (!r_oob) begin
                    w_ram_en   = 1'b1;
                    w_ram_we   = 1'b1;
                    w_ram_addr = AW'((BLK_DIM * w_brow + int'(r_cnt)) * BLK_COLS + w_bcol);
                end
            end
            ST_RD: begin
                if (r_cnt != 3'd7) begin
                    w_ram_en = 1'b1;
                    case (r_cnt)
                        3'd0:    w_ram_addr = AW'(w_row_above * BLK_COLS + w_bcol);
                        3'd1:    w_ram_addr = AW'(w_row_above * BLK_COLS + w_bcol + 1);
                        default: begin
                            w_ram_bsel = 2'd3;
                            w_ram_addr = AW'((w_row_above + int'(r_cnt) - 2) * BLK_COLS + w_bcol - 1);
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_top_asm  = TOP_DEFAULT;
        w_left_asm = LEFT_DEFAULT;
        if (!r_oob) begin
            if (!w_y0) begin
                w_top_asm = {(w_xr ? {4{r_top_lo[31:24]}} : r_top_hi), r_top_lo};
            end
            if (!w_x0) begin
                w_left_asm = {w_ram_rbyte, r_left_lo[31:8],
                              (w_y0 ? PIX_DEFAULT : r_left_lo[7:0])};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_idx      <= 13'd0;
            r_oob      <= 1'b0;
            r_blk      <= '0;
            r_in_ready <= 1'b0;
            r_err      <= 1'b0;
            r_top_lo   <= '0;
            r_top_hi   <= '0;
            r_left_lo  <= '0;
            r_top_out  <= '0;
            r_left_out <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == ST_IDLE);
            r_err      <= (w_accept_wr || w_accept_rd) && w_new_oob;
            r_cnt      <= (w_state_nxt != r_state) ? 3'd0 : r_cnt + 3'd1;
            if (w_accept_wr) begin
                r_blk <= blk;
            end
            if (w_accept_wr || w_accept_rd) begin
                r_idx <= w_new_idx;
                r_oob <= w_new_oob;
            end
            // Read data lags its address by one count.
            if (r_state == ST_RD) begin
                case (r_cnt)
                    3'd1: r_top_lo         <= w_ram_rdata;
                    3'd2: r_top_hi         <= w_ram_rdata;
                    3'd3: r_left_lo[7:0]   <= w_ram_rbyte;
                    3'd4: r_left_lo[15:8]  <= w_ram_rbyte;
                    3'd5: r_left_lo[23:16] <= w_ram_rbyte;
                    3'd6: r_left_lo[31:24] <= w_ram_rbyte;
                    3'd7: begin
                        r_top_out  <= w_top_asm;
                        r_left_out <= w_left_asm;
                    end
                    default: ;
                endcase
            end
        end
    end

    recon_frame_ram #(
        .DEPTH (WORDS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .i_bsel  (w_ram_bsel),
        .o_rdata (w_ram_rdata),
        .o_rbyte (w_ram_rbyte)
    );

endmodule
`default_nettype wire

// File: tb/tb_recon_writer_luma4x4.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_recon_writer_luma4x4
// Description : Self-checking bench for recon_writer_luma4x4 with a
//               pixel-array reference model of the reconstructed frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_recon_writer_luma4x4;

    localparam int LEN  = 256;
    localparam int WID  = 256;
    localparam int COLS = WID / 4;
    localparam int NBLK = COLS * (LEN / 4);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [12:0]  blknumber = '0;
    logic [127:0] blk = '0;
    logic         nb_req = 1'b0;
    logic [12:0]  nb_blknumber = '0;
    logic         nb_valid;
    logic [63:0]  toppixels;
    logic [39:0]  leftpixels;
    logic         busy;
    logic         err;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] frame [LEN][WID];

    always #5 clk = ~clk;

    recon_writer_luma4x4 #(.LENGTH(LEN), .WIDTH(WID)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .blknumber    (blknumber),
        .blk          (blk),
        .nb_req       (nb_req),
        .nb_blknumber (nb_blknumber),
        .nb_valid     (nb_valid),
        .toppixels    (toppixels),
        .leftpixels   (leftpixels),
        .busy         (busy),
        .err          (err)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- reference model ----------------
    task automatic model_write(input int idx, input logic [127:0] d);
        int y, x;
        y = (idx / COLS) * 4;
        x = (idx % COLS) * 4;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                frame[y + r][x + c] = d[8*(4*r + c) +: 8];
    endtask

    function automatic logic [63:0] model_top(input int idx);
        logic [63:0] t;
        int y, x;
        t = '0;
        y = (idx / COLS) * 4;
        x = (idx % COLS) * 4;
        for (int j = 0; j < 8; j++) begin
            if (idx >= NBLK || y == 0) t[8*j +: 8] = 8'd128;
            else if (x + j < WID)      t[8*j +: 8] = frame[y - 1][x + j];
            else                       t[8*j +: 8] = frame[y - 1][WID - 1];
        end
        return t;
    endfunction

    function automatic logic [39:0] model_left(input int idx);
        logic [39:0] l;
        int y, x;
        l = '0;
        y = (idx / COLS) * 4;
        x = (idx % COLS) * 4;
        for (int i = 0; i < 5; i++) begin
            if (idx >= NBLK || x == 0) l[8*i +: 8] = 8'd128;
            else if (i == 0 && y == 0) l[8*i +: 8] = 8'd128;
            else                       l[8*i +: 8] = frame[y + i - 1][x - 1];
        end
        return l;
    endfunction

    // ---------------- transactions ----------------
    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check_eq("ready_wait", in_ready, 1'b1);
    endtask

    // Write one block; returns five cycles later (cycle 5) unless idx is out of range.
    task automatic do_write(input int idx, input logic [127:0] d, input bit chk);
        logic [4:0] rdy;
        logic e1, e2;
        bit oob;
        oob = (idx >= NBLK);
        wait_ready();
        in_valid  = 1'b1;
        blknumber = 13'(idx);
        blk       = d;
        tick();                       // cycle 1
        in_valid  = 1'b0;
        e1 = err;
        rdy[0] = in_ready;
        tick();
        e2 = err;
        rdy[1] = in_ready;
        for (int k = 2; k < 5; k++) begin
            tick();
            rdy[k] = in_ready;
        end
        if (!oob) model_write(idx, d);
        if (chk) begin
            check_eq("wr_ready_pattern", rdy, oob ? 5'b11110 : 5'b10000);
            check_eq("wr_err_cycle1", e1, oob);
            check_eq("wr_err_cycle2", e2, 1'b0);
        end
    endtask

    task automatic do_read(input int idx, input bit chk_left);
        int c;
        logic e1;
        wait_ready();
        nb_req       = 1'b1;
        nb_blknumber = 13'(idx);
        tick();                       // cycle 1
        e1 = err;
        c = 1;
        while (!nb_valid && c < 20) begin
            tick();
            c++;
        end
        nb_req = 1'b0;
        check_eq("rd_valid_cycle", c, 9);
        check_eq("rd_err_cycle1", e1, (idx >= NBLK));
        check_eq("rd_top", toppixels, model_top(idx));
        if (chk_left) check_eq("rd_left", leftpixels, model_left(idx));
        tick();
        check_eq("rd_valid_pulse", nb_valid, 1'b0);
    endtask

    initial begin
        logic [127:0] d;
        int c, idx, r;

        // ---- reset ----
        tick();
        tick();
        check_eq("rst_ctrl", {in_ready, nb_valid, err, busy}, 4'b0000);
        check_eq("rst_data", {toppixels, leftpixels}, 104'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_ready_before_clk", in_ready, 1'b0);
        tick();
        check_eq("rst_ready_after_clk", in_ready, 1'b1);

        // ---- idx 0 with pixels 0..15, neighbours of idx 1 ----
        for (int p = 0; p < 16; p++) d[8*p +: 8] = 8'(p);
        do_write(0, d, 1'b1);
        do_read(1, 1'b1);
        check_eq("idx1_left_fixed", leftpixels, {8'h0F, 8'h0B, 8'h07, 8'h03, 8'h80});
        check_eq("idx1_top_fixed", toppixels, {8{8'h80}});

        // ---- top row from two blocks ----
        do_write(0, {16{8'h11}}, 1'b1);
        do_write(1, {16{8'h22}}, 1'b1);
        do_read(64, 1'b1);
        check_eq("idx64_top_fixed", toppixels, {32'h22222222, 32'h11111111});
        check_eq("idx64_left_fixed", leftpixels, {5{8'h80}});

        // ---- right edge replication; previous response must hold meanwhile ----
        do_write(63, {16{8'h55}}, 1'b1);
        check_eq("resp_hold", toppixels, {32'h22222222, 32'h11111111});
        do_read(127, 1'b0);
        check_eq("idx127_top_fixed", toppixels, {8{8'h55}});

        // ---- simultaneous write and request: write goes first ----
        do_write(64, rand128(), 1'b1);
        wait_ready();
        d            = rand128();
        in_valid     = 1'b1;
        blknumber    = 13'd2;
        blk          = d;
        nb_req       = 1'b1;
        nb_blknumber = 13'd65;
        tick();
        in_valid = 1'b0;
        model_write(2, d);
        c = 1;
        while (!nb_valid && c < 30) begin
            tick();
            c++;
        end
        nb_req = 1'b0;
        check_eq("both_valid_cycle", c, 14);
        check_eq("both_top", toppixels, model_top(65));
        check_eq("both_left", leftpixels, model_left(65));
        tick();

        // ---- out-of-range write and read ----
        do_write(4096, rand128(), 1'b1);
        do_read(65, 1'b1);
        do_read(5000, 1'b1);

        // ---- reset in the middle of a write ----
        wait_ready();
        in_valid  = 1'b1;
        blknumber = 13'd130;
        blk       = rand128();
        tick();                       // cycle 1
        in_valid = 1'b0;
        tick();                       // cycle 2
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_ctrl", {in_ready, nb_valid, err, busy}, 4'b0000);
        check_eq("abort_data", {toppixels, leftpixels}, 104'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("abort_ready_after_clk", in_ready, 1'b1);

        // ---- fill whole frame with random data ----
        for (int b = 0; b < NBLK; b++) do_write(b, rand128(), 1'b0);

        // ---- random mix of writes and reads ----
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                idx = $urandom_range(NBLK, 8191);
            end else if (r < 30) begin
                case ($urandom_range(0, 5))
                    0:       idx = 0;
                    1:       idx = COLS - 1;
                    2:       idx = COLS;
                    3:       idx = 2 * COLS - 1;
                    4:       idx = NBLK - COLS;
                    default: idx = NBLK - 1;
                endcase
            end else begin
                idx = $urandom_range(0, NBLK - 1);
            end
            if ($urandom_range(0, 1) == 1) do_write(idx, rand128(), 1'b1);
            else                           do_read(idx, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
